// File: rtl/final2_soc_nios2_qsys_0_ocimem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : final2_soc_nios2_qsys_0_ocimem_arbiter
//  Purpose  : Shares one single-port OCI RAM between the JTAG debug path and
//             the CPU data port. Each grant performs exactly one RAM operation.
//             Writes take one cycle and reads take two. Ties between the two
//             requesters are broken round-robin.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                      : single clock, rising edge
//    reset                    : synchronous, active-high
//    jdo[37:0]                : JTAG data ([AW-1:0] addr, [34:3] wdata,
//                               [35] read-after-load)
//    take_action_ocimem_a     : JTAG strobe, load address (+ read if jdo[35])
//    take_action_ocimem_b     : JTAG strobe, write jdo[34:3] at JTAG address
//    take_no_action_ocimem_a  : JTAG strobe, read at JTAG address
//    cpu_address/read/write/writedata : CPU request, held until accepted
//    cpu_waitrequest          : CPU request not yet accepted
//    cpu_readdata/readdatavalid : CPU read return
//    ram_address/wren/wdata   : RAM command
//    ram_rdata                : RAM read data, one cycle after the read issue
//    MonDReg                  : last JTAG read data
//    monitor_ready            : last JTAG operation complete
//    monitor_error            : sticky JTAG overrun flag
// ============================================================================
module final2_soc_nios2_qsys_0_ocimem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  input  logic          take_no_action_ocimem_a,
  input  logic [AW-1:0] cpu_address,
  input  logic          cpu_read,
  input  logic          cpu_write,
  input  logic [DW-1:0] cpu_writedata,
  output logic          cpu_waitrequest,
  output logic [DW-1:0] cpu_readdata,
  output logic          cpu_readdatavalid,
  output logic [AW-1:0] ram_address,
  output logic          ram_wren,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] MonDReg,
  output logic          monitor_ready,
  output logic          monitor_error
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    J_ISSUE = 3'd1,
    J_CAPT  = 3'd2,
    C_ISSUE = 3'd3,
    C_CAPT  = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nx;

  logic [AW-1:0] jaddr;
  logic          jpend;      // JTAG op pending or in flight
  logic          jpend_wr;   // pending JTAG op is a write
  logic [DW-1:0] jwdata;
  logic          last_jtag;  // 1: JTAG was granted last, 0: CPU

  logic [DW-1:0] jdo_wdata;
  logic          take_a_rd;
  logic          op_strobe;
  logic          strobe_is_wr;
  logic          jtag_finish;
  logic          op_accept;
  logic          overrun;
  logic          jtag_req;
  logic          cpu_pend;
  logic          grant_jtag;
  logic          grant_cpu;

  // Only part of jdo is meaningful; the rest is folded here so it is
  // visibly consumed.
  logic          unused_jdo;
  assign unused_jdo = ^jdo;

  // Write data always comes from jdo[34:3]; adapt to the RAM data width.
  generate
    if (DW >= 32) begin : g_wdata_wide
      assign jdo_wdata = DW'(jdo[34:3]);
    end else begin : g_wdata_narrow
      assign jdo_wdata = jdo[DW+2:3];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // JTAG strobe decode. When several strobes coincide, the load-and-read
  // strobe wins over the write, and the write wins over the plain read.
  // --------------------------------------------------------------------------
  assign take_a_rd    = take_action_ocimem_a & jdo[35];
  assign op_strobe    = take_a_rd | take_action_ocimem_b | take_no_action_ocimem_a;
  assign strobe_is_wr = ~take_a_rd & take_action_ocimem_b;

  // The JTAG op completes in this cycle: a write in its issue cycle or a
  // read in its capture cycle. A strobe landing here reuses the slot.
  assign jtag_finish  = (state == J_CAPT) | ((state == J_ISSUE) & jpend_wr);
  assign op_accept    = op_strobe & (~jpend | jtag_finish);
  assign overrun      = op_strobe & ~op_accept;

  // A strobe accepted this cycle already counts as a request, so the JTAG
  // issue starts in the cycle right after the strobe.
  assign jtag_req     = jpend | op_accept;
  assign cpu_pend     = cpu_read | cpu_write;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        // JTAG goes first unless the CPU is also waiting and JTAG had the
        // previous grant.
        if (jtag_req && (!cpu_pend || !last_jtag)) begin
          state_nx = J_ISSUE;
        end else if (cpu_pend) begin
          state_nx = C_ISSUE;
        end
      end
      J_ISSUE: state_nx = jpend_wr ? IDLE : J_CAPT;
      J_CAPT:  state_nx = IDLE;
      C_ISSUE: state_nx = (cpu_read && !cpu_write) ? C_CAPT : IDLE;
      C_CAPT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign grant_jtag = (state == IDLE) && (state_nx == J_ISSUE);
  assign grant_cpu  = (state == IDLE) && (state_nx == C_ISSUE);

  // --------------------------------------------------------------------------
  // RAM command. Outside C_ISSUE the address shows the JTAG pointer; only the
  // issue states can raise the write enable, and reset forces it low.
  // --------------------------------------------------------------------------
  assign ram_address = (state == C_ISSUE) ? cpu_address   : jaddr;
  assign ram_wdata   = (state == C_ISSUE) ? cpu_writedata : jwdata;
  assign ram_wren    = ~reset & (((state == J_ISSUE) & jpend_wr) |
                                 ((state == C_ISSUE) & cpu_write));

  // The CPU request is accepted only in C_ISSUE and never while in reset.
  assign cpu_waitrequest = cpu_pend & (reset | (state != C_ISSUE));

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      jaddr             <= '0;
      jpend             <= 1'b0;
      jpend_wr          <= 1'b0;
      jwdata            <= '0;
      last_jtag         <= 1'b0;
      MonDReg           <= '0;
      cpu_readdata      <= '0;
      cpu_readdatavalid <= 1'b0;
      monitor_ready     <= 1'b0;
      monitor_error     <= 1'b0;
    end else begin
      state <= state_nx;

      if (grant_jtag) begin
        last_jtag <= 1'b1;
      end else if (grant_cpu) begin
        last_jtag <= 1'b0;
      end

      // CPU read return: RAM data is valid during C_CAPT, so it is captured
      // at the end of that cycle and presented with a one-cycle valid pulse.
      cpu_readdatavalid <= (state == C_CAPT);
      if (state == C_CAPT) begin
        cpu_readdata <= ram_rdata;
      end

      if (state == J_CAPT) begin
        MonDReg <= ram_rdata;
      end

      // An explicit address load overrides the post-operation increment.
      if (take_action_ocimem_a) begin
        jaddr <= jdo[AW-1:0];
      end else if (jtag_finish) begin
        jaddr <= jaddr + AW'(1);
      end

      if (op_accept) begin
        jpend    <= 1'b1;
        jpend_wr <= strobe_is_wr;
        if (strobe_is_wr) begin
          jwdata <= jdo_wdata;
        end
      end else if (jtag_finish) begin
        jpend <= 1'b0;
      end

      // A newly accepted op makes the monitor busy again even if the
      // previous one completes in the same cycle.
      if (op_accept) begin
        monitor_ready <= 1'b0;
      end else if (jtag_finish) begin
        monitor_ready <= 1'b1;
      end

      if (overrun) begin
        monitor_error <= 1'b1;
      end else if (take_action_ocimem_a) begin
        monitor_error <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_final2_soc_nios2_qsys_0_ocimem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_final2_soc_nios2_qsys_0_ocimem_arbiter
//  Purpose  : Directed self-checking bench for the OCI RAM arbiter, with a
//             behavioural single-port RAM attached to the RAM command port.
//  Revision : 1.0  initial release
// ============================================================================
module tb_final2_soc_nios2_qsys_0_ocimem_arbiter;

  logic        clk;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [7:0]  cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_writedata;
  logic        cpu_waitrequest;
  logic [31:0] cpu_readdata;
  logic        cpu_readdatavalid;
  logic [7:0]  ram_address;
  logic        ram_wren;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int tests_run;
  int tests_failed;

  logic [31:0] mem [0:255];

  final2_soc_nios2_qsys_0_ocimem_arbiter #(
    .AW(8),
    .DW(32)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .cpu_address             (cpu_address),
    .cpu_read                (cpu_read),
    .cpu_write               (cpu_write),
    .cpu_writedata           (cpu_writedata),
    .cpu_waitrequest         (cpu_waitrequest),
    .cpu_readdata            (cpu_readdata),
    .cpu_readdatavalid       (cpu_readdatavalid),
    .ram_address             (ram_address),
    .ram_wren                (ram_wren),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM: registered read, data one cycle after the address.
  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_wdata;
    ram_rdata <= mem[ram_address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [37:0] mk_jdo(input logic rd, input logic [31:0] d, input logic [7:0] a);
    logic [37:0] j;
    j        = '0;
    j[34:3]  = d;
    j[35]    = rd;
    j[7:0]   = j[7:0] | a;
    return j;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0100_0000 + i;
    mem[8'h10] = 32'hDEAD_BEEF;
    mem[8'h20] = 32'hCAFE_F00D;

    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    cpu_address = 8'h20;
    cpu_read = 1'b1;
    cpu_write = 1'b0;
    cpu_writedata = '0;

    // ---- reset state, with a CPU request present ----
    step();
    step();
    check("rst_waitreq", cpu_waitrequest, 1);
    check("rst_wren", ram_wren, 0);
    check("rst_rdv", cpu_readdatavalid, 0);
    check("rst_mondreg", MonDReg, 0);
    check("rst_ready", monitor_ready, 0);
    check("rst_error", monitor_error, 0);
    check("rst_cpurd", cpu_readdata, 0);
    check("rst_addr", ram_address, 0);
    cpu_read = 1'b0;
    reset = 1'b0;
    step();

    // ---- JTAG load + read of 0x10 ----
    jdo = mk_jdo(1'b1, 32'h0, 8'h10);
    take_action_ocimem_a = 1'b1;
    step();                                   // J_ISSUE
    take_action_ocimem_a = 1'b0;
    check("jrd_addr", ram_address, 8'h10);
    check("jrd_wren", ram_wren, 0);
    check("jrd_busy", monitor_ready, 0);
    step();                                   // J_CAPT
    step();                                   // IDLE
    check("jrd_mondreg", MonDReg, 32'hDEAD_BEEF);
    check("jrd_ready", monitor_ready, 1);
    check("jrd_jaddr", ram_address, 8'h11);

    // ---- JTAG write at 0xFF, address wraps ----
    jdo = mk_jdo(1'b0, 32'h0, 8'hFF);
    take_action_ocimem_a = 1'b1;
    step();
    take_action_ocimem_a = 1'b0;
    check("jld_addr", ram_address, 8'hFF);
    check("jld_error", monitor_error, 0);
    check("jld_ready", monitor_ready, 1);
    jdo = mk_jdo(1'b0, 32'h1234_5678, 8'h00);
    take_action_ocimem_b = 1'b1;
    step();                                   // J_ISSUE (write)
    take_action_ocimem_b = 1'b0;
    check("jwr_wren", ram_wren, 1);
    check("jwr_addr", ram_address, 8'hFF);
    check("jwr_wdata", ram_wdata, 32'h1234_5678);
    check("jwr_busy", monitor_ready, 0);
    step();                                   // IDLE
    check("jwr_wren_off", ram_wren, 0);
    check("jwr_wrap", ram_address, 8'h00);
    check("jwr_ready", monitor_ready, 1);
    check("jwr_mem", mem[8'hFF], 32'h1234_5678);

    // ---- overrun: second strobe while the first is in J_ISSUE ----
    take_no_action_ocimem_a = 1'b1;
    step();                                   // J_ISSUE, strobe still high
    check("ovr_addr", ram_address, 8'h00);
    step();                                   // J_CAPT
    take_no_action_ocimem_a = 1'b0;
    check("ovr_error", monitor_error, 1);
    step();                                   // IDLE
    check("ovr_mondreg", MonDReg, 32'h0100_0000);
    check("ovr_ready", monitor_ready, 1);
    check("ovr_jaddr", ram_address, 8'h01);
    step();
    check("ovr_dropped", ram_address, 8'h01);
    check("ovr_sticky", monitor_error, 1);
    jdo = mk_jdo(1'b0, 32'h0, 8'h05);
    take_action_ocimem_a = 1'b1;
    step();
    take_action_ocimem_a = 1'b0;
    check("ovr_clear", monitor_error, 0);
    check("ovr_load", ram_address, 8'h05);

    // ---- strobe in the finishing cycle is accepted ----
    take_no_action_ocimem_a = 1'b1;
    step();                                   // J_ISSUE
    take_no_action_ocimem_a = 1'b0;
    step();                                   // J_CAPT
    take_no_action_ocimem_a = 1'b1;
    step();                                   // IDLE
    take_no_action_ocimem_a = 1'b0;
    check("fin_error", monitor_error, 0);
    check("fin_ready", monitor_ready, 0);
    check("fin_mondreg", MonDReg, 32'h0100_0005);
    step();                                   // J_ISSUE
    check("fin_addr", ram_address, 8'h06);
    step();                                   // J_CAPT
    step();                                   // IDLE
    check("fin_mondreg2", MonDReg, 32'h0100_0006);
    check("fin_ready2", monitor_ready, 1);
    check("fin_jaddr", ram_address, 8'h07);

    // ---- tie out of reset: JTAG first, then repeat tie goes to CPU ----
    do_reset();
    cpu_address = 8'h20;
    cpu_read = 1'b1;
    take_no_action_ocimem_a = 1'b1;
    step();                                   // J_ISSUE
    take_no_action_ocimem_a = 1'b0;
    check("tie_jfirst", ram_address, 8'h00);
    check("tie_wait1", cpu_waitrequest, 1);
    step();                                   // J_CAPT
    check("tie_wait2", cpu_waitrequest, 1);
    step();                                   // IDLE
    check("tie_wait3", cpu_waitrequest, 1);
    check("tie_mondreg", MonDReg, 32'h0100_0000);
    take_no_action_ocimem_a = 1'b1;
    step();                                   // C_ISSUE (CPU wins repeat tie)
    take_no_action_ocimem_a = 1'b0;
    check("tie_accept", cpu_waitrequest, 0);
    check("tie_caddr", ram_address, 8'h20);
    check("tie_cwren", ram_wren, 0);
    step();                                   // C_CAPT
    cpu_read = 1'b0;
    check("tie_rdv_early", cpu_readdatavalid, 0);
    step();                                   // IDLE
    check("tie_rdv", cpu_readdatavalid, 1);
    check("tie_rdata", cpu_readdata, 32'hCAFE_F00D);
    step();                                   // J_ISSUE
    check("tie_rdv_pulse", cpu_readdatavalid, 0);
    check("tie_j2addr", ram_address, 8'h01);
    check("tie_rdata_hold", cpu_readdata, 32'hCAFE_F00D);
    step();                                   // J_CAPT
    step();                                   // IDLE
    check("tie_mondreg2", MonDReg, 32'h0100_0001);

    // ---- reset during C_CAPT aborts the CPU read ----
    cpu_address = 8'h10;
    cpu_read = 1'b1;
    step();                                   // C_ISSUE
    check("rca_accept", cpu_waitrequest, 0);
    step();                                   // C_CAPT
    reset = 1'b1;
    step();                                   // reset applied
    check("rca_rdv", cpu_readdatavalid, 0);
    check("rca_rdata", cpu_readdata, 0);
    check("rca_mondreg", MonDReg, 0);
    check("rca_ready", monitor_ready, 0);
    check("rca_waitreq", cpu_waitrequest, 1);
    check("rca_wren", ram_wren, 0);
    check("rca_jaddr", ram_address, 8'h00);
    step();
    check("rca_rdv2", cpu_readdatavalid, 0);
    cpu_read = 1'b0;
    reset = 1'b0;
    step();

    // ---- continuous CPU writes with JTAG reads: grants alternate ----
    cpu_address = 8'h40;
    cpu_writedata = 32'hA000_0000;
    cpu_write = 1'b1;
    take_no_action_ocimem_a = 1'b1;
    step();                                   // J_ISSUE (last = CPU)
    take_no_action_ocimem_a = 1'b0;
    check("alt_j1", ram_address, 8'h00);
    check("alt_j1_wait", cpu_waitrequest, 1);
    step();                                   // J_CAPT
    step();                                   // IDLE
    take_no_action_ocimem_a = 1'b1;
    step();                                   // C_ISSUE (last = JTAG)
    take_no_action_ocimem_a = 1'b0;
    check("alt_c1_wait", cpu_waitrequest, 0);
    check("alt_c1_wren", ram_wren, 1);
    check("alt_c1_addr", ram_address, 8'h40);
    step();                                   // IDLE
    check("alt_idle_wait", cpu_waitrequest, 1);
    step();                                   // J_ISSUE (last = CPU)
    check("alt_j2", ram_address, 8'h01);
    check("alt_j2_wren", ram_wren, 0);
    step();                                   // J_CAPT
    step();                                   // IDLE
    check("alt_mondreg", MonDReg, 32'h0100_0001);
    check("alt_ready", monitor_ready, 1);
    step();                                   // C_ISSUE
    check("alt_c2_wait", cpu_waitrequest, 0);
    cpu_write = 1'b0;
    step();
    check("alt_mem", mem[8'h40], 32'hA000_0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
